// File: rtl/matrix_product_sequencer.sv
// Sequences an N x N matrix product through an external inner-product unit:
// one (row of A, column of B) pair per element, results gathered into C in row-major order.
module matrix_product_sequencer #(
    parameter int unsigned N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [32*N*N-1:0]     a_in,
    input  logic [32*N*N-1:0]     b_in,
    output logic [32*N-1:0]       row,
    output logic [32*N-1:0]       column,
    output logic                  row_o_stb,
    output logic                  column_o_stb,
    input  logic                  row_i_ack,
    input  logic                  column_i_ack,
    input  logic [31:0]           res_in,
    input  logic                  res_i_stb,
    output logic                  res_o_ack,
    output logic [32*N*N-1:0]     c_out,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned W     = 32;
    localparam int unsigned ROW_W = W * N;
    localparam int unsigned MAT_W = W * N * N;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, ISSUE, WAIT_RES, RELEASE, NEXT, FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [MAT_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [ROW_W-1:0]   row_q, row_d, col_q, col_d;
    logic [IDX_W-1:0]   i_q, i_d, j_q, j_d;
    logic               ack_r_q, ack_r_d, ack_c_q, ack_c_d;
    logic               busy_q, busy_d;
    logic               done_q, stb_q, res_ack_q;

    // Next-state, datapath and operand selection
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        row_d   = row_q;
        col_d   = col_q;
        i_d     = i_q;
        j_d     = j_q;
        ack_r_d = ack_r_q;
        ack_c_d = ack_c_q;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    i_d     = '0;
                    j_d     = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = ISSUE;
            ISSUE: begin
                ack_r_d = ack_r_q | row_i_ack;
                ack_c_d = ack_c_q | column_i_ack;
                if (ack_r_d && ack_c_d) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_i_stb) begin
                    c_d[W*(32'(i_q)*N + 32'(j_q)) +: W] = res_in;
                    state_d = RELEASE;
                end
            end
            // Hold here until the result strobe drops so a held strobe is captured once
            RELEASE: begin
                if (!res_i_stb) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (j_q == LAST_IDX) begin
                    j_d = '0;
                    if (i_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        i_d     = i_q + IDX_W'(1);
                        state_d = LOAD;
                    end
                end else begin
                    j_d     = j_q + IDX_W'(1);
                    state_d = LOAD;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Entering LOAD: drop stale acks and present the operands of the new (i,j)
        if (state_d == LOAD) begin
            ack_r_d = 1'b0;
            ack_c_d = 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                row_d[W*k +: W] = a_d[W*(32'(i_d)*N + k) +: W];
                col_d[W*k +: W] = b_d[W*(k*N + 32'(j_d)) +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            ack_r_q   <= 1'b0;
            ack_c_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stb_q     <= 1'b0;
            res_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            row_q     <= row_d;
            col_q     <= col_d;
            i_q       <= i_d;
            j_q       <= j_d;
            ack_r_q   <= ack_r_d;
            ack_c_q   <= ack_c_d;
            busy_q    <= busy_d;
            done_q    <= (state_d == FINISH);
            stb_q     <= (state_d == ISSUE);
            res_ack_q <= (state_d == ISSUE) || (state_d == WAIT_RES);
        end
    end

    assign row          = row_q;
    assign column       = col_q;
    assign row_o_stb    = stb_q;
    assign column_o_stb = stb_q;
    assign res_o_ack    = res_ack_q;
    assign c_out        = c_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_matrix_product_sequencer.sv
// Randomized bench for matrix_product_sequencer: a behavioural inner-product responder
// with configurable handshake timing, checked against a matrix-level reference model.
module tb_matrix_product_sequencer;

    localparam int N     = 4;
    localparam int ROW_W = 32 * N;
    localparam int MAT_W = 32 * N * N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start;
    logic [MAT_W-1:0] a_in, b_in, c_out;
    logic [ROW_W-1:0] row, column;
    logic             row_o_stb, column_o_stb, res_o_ack, busy, done;
    logic             row_i_ack, column_i_ack, res_i_stb;
    logic [31:0]      res_in;

    matrix_product_sequencer #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .row(row), .column(column), .row_o_stb(row_o_stb), .column_o_stb(column_o_stb),
        .row_i_ack(row_i_ack), .column_i_ack(column_i_ack), .res_in(res_in),
        .res_i_stb(res_i_stb), .res_o_ack(res_o_ack), .c_out(c_out), .busy(busy), .done(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [MAT_W-1:0] got, input logic [MAT_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference operands and responder configuration
    logic [31:0] ma[N][N];
    logic [31:0] mb[N][N];
    int mode;                       // 0 hash, 1 identity-float, 2 index tag
    int lat_r, lat_c, res_lat, res_hold;
    bit noise;
    int issue_n, done_n, cap_n;

    function automatic logic [MAT_W-1:0] flat_a();
        logic [MAT_W-1:0] v;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) v[32*(r*N+c) +: 32] = ma[r][c];
        return v;
    endfunction

    function automatic logic [MAT_W-1:0] flat_b();
        logic [MAT_W-1:0] v;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) v[32*(r*N+c) +: 32] = mb[r][c];
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] exp_row(input int i);
        logic [ROW_W-1:0] v;
        for (int k = 0; k < N; k++) v[32*k +: 32] = ma[i][k];
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] exp_col(input int j);
        logic [ROW_W-1:0] v;
        for (int k = 0; k < N; k++) v[32*k +: 32] = mb[k][j];
        return v;
    endfunction

    // Inner-product unit behaviour for the current mode
    function automatic logic [31:0] resp(input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] c);
        logic [31:0] acc;
        logic [31:0] ce;
        acc = '0;
        for (int k = 0; k < N; k++) begin
            ce = c[32*k +: 32];
            if (mode == 0) acc = acc * 32'd31 + (r[32*k +: 32] ^ {ce[15:0], ce[31:16]});
            else if (mode == 1 && r[32*k +: 32] == 32'h3F80_0000) acc = ce;
        end
        if (mode == 2) acc = {20'h0, r[3:0], c[3:0], 4'h0};
        return acc;
    endfunction

    function automatic logic [MAT_W-1:0] exp_hash();
        logic [MAT_W-1:0] v;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) v[32*(i*N+j) +: 32] = resp(exp_row(i), exp_col(j));
        return v;
    endfunction

    function automatic logic [MAT_W-1:0] exp_tag();
        logic [MAT_W-1:0] v;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) v[32*(i*N+j) +: 32] = 32'((i << 8) | (j << 4));
        return v;
    endfunction

    task automatic fill(input int kind);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (kind == 1) ma[r][c] = (r == c) ? 32'h3F80_0000 : 32'h0;
                else if (kind == 2) ma[r][c] = 32'(r);
                else ma[r][c] = $urandom;
                mb[r][c] = (kind == 2) ? 32'(c) : $urandom;
            end
    endtask

    // Responder: acks after programmable delays, result after res_lat, held res_hold cycles
    int ic = 0, wc = 0, hold_left = 0;
    always @(negedge clk) begin
        if (!rst) begin
            row_i_ack = 1'b0; column_i_ack = 1'b0; res_i_stb = 1'b0;
            ic = 0; wc = 0; hold_left = 0;
        end else begin
            row_i_ack = 1'b0; column_i_ack = 1'b0;
            if (row_o_stb) begin
                row_i_ack    = (ic == lat_r);
                column_i_ack = (ic == lat_c);
                ic++;
            end else begin
                ic = 0;
                if (noise) begin
                    row_i_ack    = 1'($urandom_range(0, 1));
                    column_i_ack = 1'($urandom_range(0, 1));
                end
            end
            if (res_i_stb) begin
                hold_left--;
                if (hold_left == 0) res_i_stb = 1'b0;
                else res_in = $urandom;     // only the first strobe cycle carries a valid result
            end else if (res_o_ack && !row_o_stb) begin
                if (wc == res_lat) begin
                    res_i_stb = 1'b1;
                    res_in    = resp(row, column);
                    hold_left = res_hold;
                    wc        = 0;
                    cap_n++;
                end else wc++;
            end else wc = 0;
        end
    end

    // Monitor: issue order/operands, strobe width, done pulses
    logic prev_stb = 1'b0;
    int   dur = 0;
    always begin
        @(posedge clk); #1;
        if (rst) begin
            if (row_o_stb && !prev_stb) begin
                if (issue_n < N*N) begin
                    check("issue_row", row, exp_row(issue_n / N));
                    check("issue_col", column, exp_col(issue_n % N));
                end
                check("issue_res_low", res_i_stb, 0);
                issue_n++;
                dur = 0;
            end
            if (row_o_stb) dur++;
            if (!row_o_stb && prev_stb)
                check("stb_width", dur, ((lat_r > lat_c) ? lat_r : lat_c) + 1);
            if (done) done_n++;
        end
        prev_stb = row_o_stb;
    end

    task automatic run_product(input logic [MAT_W-1:0] exp_c, input bit chk_cyc, input bit mid_start);
        int cyc;
        bit seen;
        issue_n = 0; done_n = 0; cap_n = 0;
        a_in = flat_a(); b_in = flat_b();
        @(negedge clk);
        start = 1'b1;
        cyc = 1; seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) check("busy_on_start", busy, 1);
            start = mid_start && (cyc == 30);
            if (mid_start && cyc == 30) begin
                a_in = {16{$urandom}};
                b_in = {16{$urandom}};
            end
            seen = done;
        end
        check("done_seen", seen, 1);
        if (chk_cyc) check("latency", cyc, 82);
        repeat (2) @(posedge clk);
        #1;
        check("c_out", c_out, exp_c);
        check("done_count", done_n, 1);
        check("busy_idle", busy, 0);
        check("issue_count", issue_n, N*N);
        check("capture_count", cap_n, N*N);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; a_in = '0; b_in = '0; res_in = '0;
        row_i_ack = 1'b0; column_i_ack = 1'b0; res_i_stb = 1'b0;
        mode = 0; lat_r = 0; lat_c = 0; res_lat = 0; res_hold = 1; noise = 1'b0;
        issue_n = 0; done_n = 0; cap_n = 0;
        repeat (3) @(negedge clk);
        check("reset_ctl", {busy, done, row_o_stb, column_o_stb, res_o_ack}, 0);
        check("reset_ops", {row, column}, 0);
        check("reset_c", c_out, 0);
        rst = 1'b1;
        @(negedge clk);

        mode = 1; fill(1); run_product(flat_b(), 1, 0);
        mode = 2; fill(2); run_product(exp_tag(), 1, 0);

        mode = 0; fill(0); lat_r = 0; lat_c = 3; run_product(exp_hash(), 0, 0);
        fill(0); lat_r = 2; lat_c = 0; run_product(exp_hash(), 0, 0);
        fill(0); lat_r = 0; lat_c = 0; res_lat = 1; res_hold = 5; run_product(exp_hash(), 0, 0);
        fill(0); res_lat = 0; res_hold = 1; run_product(exp_hash(), 1, 1);

        for (int r = 0; r < 6; r++) begin
            fill(0);
            lat_r = $urandom_range(0, 3); lat_c = $urandom_range(0, 3);
            res_lat = $urandom_range(0, 3); res_hold = $urandom_range(1, 4);
            noise = 1'($urandom_range(0, 1));
            run_product(exp_hash(), 0, 0);
        end

        // Reset while element (2,1) is being issued
        noise = 1'b0; lat_r = 1; lat_c = 2; res_lat = 0; res_hold = 1;
        fill(0);
        issue_n = 0;
        a_in = flat_a(); b_in = flat_b();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int t = 0; t < 500 && issue_n < 10; t++) begin
            @(posedge clk); #3;
        end
        check("reach_elem_21", issue_n, 10);
        rst = 1'b0;
        #1;
        check("midrst_ctl", {busy, done, row_o_stb, column_o_stb, res_o_ack}, 0);
        check("midrst_ops", {row, column}, 0);
        check("midrst_c", c_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_rst", {busy, row_o_stb, res_o_ack}, 0);
        fill(0); run_product(exp_hash(), 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_product_sequencer.md
MATRIX_PRODUCT_SEQUENCER -- requirements
Module: matrix_product_sequencer

Interface
REQ-001 Parameter: N, 4, matrix dimension (N x N operands); word width fixed at 32 bits, element (r,c) of any flat matrix bus at bits [32*(r*N+c) +: 32].
REQ-002 clk  input  1  clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one full product; sampled only in IDLE.
REQ-005 a_in  input  32*N*N  operand matrix A, row-major.
REQ-006 b_in  input  32*N*N  operand matrix B, row-major.
REQ-007 row  output  32*N  row i of A, element k at bits [32*k +: 32].
REQ-008 column  output  32*N  column j of B (B[k][j] at bits [32*k +: 32]).
REQ-009 row_o_stb / column_o_stb  output  1 each  operand strobes to inner-product unit.
REQ-010 row_i_ack / column_i_ack  input  1 each  operand acknowledges from inner-product unit.
REQ-011 res_in  input  32  dot-product result from inner-product unit.
REQ-012 res_i_stb  input  1  result valid strobe.
REQ-013 res_o_ack  output  1  result ready/acknowledge to inner-product unit.
REQ-014 c_out  output  32*N*N  result matrix C, row-major.
REQ-015 busy  output  1  high from accepted start until done.
REQ-016 done  output  1  one-cycle pulse when C complete.

Function
REQ-017 States SHALL be IDLE, LOAD, ISSUE, WAIT_RES, RELEASE, NEXT, FINISH.
REQ-018 IDLE: start=1 -> latch a_in,b_in into internal A,B registers, clear i,j to 0, busy<=1, go LOAD; start=0 -> stay.
REQ-019 LOAD: drive row/column from registered A,B for (i,j); go ISSUE next cycle.
REQ-020 ISSUE: row_o_stb=column_o_stb=1, res_o_ack=1; row/column stable throughout.
REQ-021 ISSUE: row_i_ack and column_i_ack SHALL be latched independently (may arrive in different cycles or same cycle); when both latched, drop both strobes next cycle, go WAIT_RES.
REQ-022 WAIT_RES: res_o_ack=1; first cycle with res_i_stb=1 SHALL write res_in into C[i][j] and go RELEASE.
REQ-023 RELEASE: res_o_ack=0; stay until res_i_stb=0 (prevents double capture of a held strobe), then go NEXT.
REQ-024 NEXT: advance j; on j=N-1 wrap j to 0 and advance i; if (i,j) was (N-1,N-1) go FINISH else LOAD.
REQ-025 FINISH: done=1 for exactly one cycle, busy<=0, go IDLE.
REQ-026 Elements SHALL be computed in row-major order (0,0),(0,1)...(N-1,N-1); exactly N*N issues per product.
REQ-027 c_out SHALL hold its contents from done until overwritten element-by-element by the next product; no partial clear at start.
REQ-028 start while busy SHALL be ignored; a_in/b_in changes after LOAD latch SHALL not affect the product.
REQ-029 Acks or res_i_stb arriving outside their state SHALL be ignored; stale latched acks cleared on entry to LOAD.
REQ-030 Minimum cost per element: LOAD 1 + ISSUE 1 + WAIT_RES 1 + RELEASE 1 + NEXT 1 = 5 cycles with zero-latency responder; N*N*5+2 cycles start-to-done for N=4 -> 82.
REQ-031 Block SHALL perform no arithmetic on data; results are stored bit-exact.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, i=j=0, busy=0, done=0, all strobes and res_o_ack=0, latched acks=0, c_out=0, row=column=0.
REQ-033 Reset mid-operation SHALL abandon the product; after release, block waits in IDLE for a new start.

Verification
REQ-034 N=4, A=I (1.0f=32'h3F800000 on diagonal), responder returns dot product in float -> c_out equals B exactly, done after 82 cycles with zero-latency responder.
REQ-035 Tag responder returning 32'h0000_0ij0 encoded from operand contents -> each C[i][j] lands at bits [32*(i*4+j) +: 32]; issue order strictly row-major.
REQ-036 row_i_ack in cycle t, column_i_ack in cycle t+3 -> strobes stay high through t+3, drop at t+4, result accepted only afterwards.
REQ-037 Responder holds res_i_stb high 5 cycles -> exactly one capture per element, block stays in RELEASE until strobe low, 16 captures total.
REQ-038 start pulsed again mid-product and a_in changed -> ignored; final C matches original operands; single done pulse.
REQ-039 rst asserted during element (2,1) -> all outputs reach reset values same cycle; new start yields full correct product from (0,0).
